// File: rtl/ssd1306_spi_rx_if.sv
// SSD1306 serial input and framebuffer write bus between the AVR pins and the video stage.
interface ssd1306_spi_rx_if;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 8;

  logic              oled_clk;
  logic              oled_data;
  logic              oled_dc;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              display_on;
  logic              invert;

  modport slave (
    input  oled_clk, oled_data, oled_dc,
    output fb_we, fb_addr, fb_data, display_on, invert
  );

  modport master (
    output oled_clk, oled_data, oled_dc,
    input  fb_we, fb_addr, fb_data, display_on, invert
  );
endinterface

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 serial receiver: byte assembly, command subset decode and framebuffer writes.
// Define SSD1306_VADDR_EN to build vertical addressing mode (mode 1).
module ssd1306_spi_rx (
  input  logic              clock,
  input  logic              reset,
  ssd1306_spi_rx_if.slave   bus
);
  localparam int unsigned COL_W  = 7;
  localparam int unsigned PAGE_W = 3;

  typedef enum logic [2:0] {
    CMD, ARG_CS, ARG_CE, ARG_PS, ARG_PE, ARG_MODE, ARG_SKIP
  } state_t;

  state_t              state;
  logic [2:0]          clk_sync;
  logic [1:0]          data_sync;
  logic [1:0]          dc_sync;
  logic [7:0]          shift_q;
  logic [2:0]          bit_cnt;
  logic [COL_W-1:0]    col, col_start, col_end;
  logic [PAGE_W-1:0]   page, page_start, page_end;
  logic [1:0]          mode;

  logic                edge_c;
  logic [7:0]          byte_c;
  logic [COL_W-1:0]    adv_col_c;
  logic [PAGE_W-1:0]   adv_page_c;
  logic [1:0]          mode_arg_c;

  // clk_sync[1] is the synchronized SPI clock, clk_sync[2] its previous value
  assign edge_c = clk_sync[1] & ~clk_sync[2];
  assign byte_c = {shift_q[6:0], data_sync[1]};

  // Pointer after a data write, by addressing mode
  always_comb begin
    adv_col_c  = col;
    adv_page_c = page;
    case (mode)
      2'd0: begin
        if (col == col_end) begin
          adv_col_c  = col_start;
          adv_page_c = (page == page_end) ? page_start : page + PAGE_W'(1);
        end else begin
          adv_col_c = col + COL_W'(1);
        end
      end
`ifdef SSD1306_VADDR_EN
      2'd1: begin
        if (page == page_end) begin
          adv_page_c = page_start;
          adv_col_c  = (col == col_end) ? col_start : col + COL_W'(1);
        end else begin
          adv_page_c = page + PAGE_W'(1);
        end
      end
`endif
      default: adv_col_c = (col == COL_W'(127)) ? COL_W'(0) : col + COL_W'(1);
    endcase
  end

  always_comb begin
    mode_arg_c = 2'd2;
    case (byte_c[1:0])
      2'd0:    mode_arg_c = 2'd0;
`ifdef SSD1306_VADDR_EN
      2'd1:    mode_arg_c = 2'd1;
`else
      2'd1:    mode_arg_c = 2'd0;
`endif
      default: mode_arg_c = 2'd2;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= CMD;
      clk_sync       <= '0;
      data_sync      <= '0;
      dc_sync        <= '0;
      shift_q        <= '0;
      bit_cnt        <= '0;
      col            <= '0;
      page           <= '0;
      col_start      <= '0;
      col_end        <= COL_W'(127);
      page_start     <= '0;
      page_end       <= PAGE_W'(7);
      mode           <= 2'd2;
      bus.fb_we      <= 1'b0;
      bus.fb_addr    <= '0;
      bus.fb_data    <= '0;
      bus.display_on <= 1'b0;
      bus.invert     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], bus.oled_clk};
      data_sync <= {data_sync[0], bus.oled_data};
      dc_sync   <= {dc_sync[0], bus.oled_dc};
      bus.fb_we <= 1'b0;
      if (edge_c) begin
        shift_q <= byte_c;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (dc_sync[1]) begin
            // Data byte: write, advance, drop any pending command arguments
            bus.fb_we   <= 1'b1;
            bus.fb_addr <= {page, col};
            bus.fb_data <= byte_c;
            col         <= adv_col_c;
            page        <= adv_page_c;
            state       <= CMD;
          end else begin
            case (state)
              ARG_CS: begin
                col_start <= byte_c[6:0];
                col       <= byte_c[6:0];
                state     <= ARG_CE;
              end
              ARG_CE: begin
                col_end <= byte_c[6:0];
                state   <= CMD;
              end
              ARG_PS: begin
                page_start <= byte_c[2:0];
                page       <= byte_c[2:0];
                state      <= ARG_PE;
              end
              ARG_PE: begin
                page_end <= byte_c[2:0];
                state    <= CMD;
              end
              ARG_MODE: begin
                mode  <= mode_arg_c;
                state <= CMD;
              end
              ARG_SKIP: state <= CMD;
              default: begin
                case (byte_c) inside
                  8'h21: state <= ARG_CS;
                  8'h22: state <= ARG_PS;
                  8'h20: state <= ARG_MODE;
                  8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: state <= ARG_SKIP;
                  8'hAE, 8'hAF: bus.display_on <= byte_c[0];
                  8'hA6, 8'hA7: bus.invert     <= byte_c[0];
                  [8'hB0:8'hB7]: page          <= byte_c[2:0];
                  [8'h00:8'h0F]: col[3:0]      <= byte_c[3:0];
                  [8'h10:8'h17]: col[6:4]      <= byte_c[2:0];
                  default: state <= CMD;
                endcase
              end
            endcase
          end
        end
      end
    end
  end
endmodule
